// File: rtl/regfile_mp_if.sv
// regfile_mp_if: core read/write ports and debug access port of regfile_mp
interface regfile_mp_if #(
    parameter int DataWidth  = 32,
    parameter int NumRegs    = 32,
    parameter int NumRdPorts = 2,
    parameter int NumWrPorts = 1
);
    localparam int AddrWidth = $clog2(NumRegs);
    logic [NumWrPorts-1:0]           we_i;
    logic [NumWrPorts*AddrWidth-1:0] waddr_i;
    logic [NumWrPorts*DataWidth-1:0] wdata_i;
    logic [NumRdPorts*AddrWidth-1:0] raddr_i;
    logic [NumRdPorts*DataWidth-1:0] rdata_o;
    logic                            dbg_req_i;
    logic                            dbg_we_i;
    logic [AddrWidth-1:0]            dbg_addr_i;
    logic [DataWidth-1:0]            dbg_wdata_i;
    logic                            dbg_gnt_o;
    logic                            dbg_rvalid_o;
    logic [DataWidth-1:0]            dbg_rdata_o;
    logic                            stall_o;
    modport master (
        output we_i, waddr_i, wdata_i, raddr_i, dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
        input  rdata_o, dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o, stall_o
    );
    modport slave (
        input  we_i, waddr_i, wdata_i, raddr_i, dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
        output rdata_o, dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o, stall_o
    );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with write-to-read bypass and a starvation-guarded debug port
module regfile_mp #(
    parameter int DataWidth   = 32,
    parameter int NumRegs     = 32,
    parameter int NumRdPorts  = 2,
    parameter int NumWrPorts  = 1,
    parameter int StarveLimit = 4
) (
    input logic         clk_i,
    input logic         rst_i,
    regfile_mp_if.slave bus
);
    localparam int AddrWidth = $clog2(NumRegs);
    localparam int CntWidth  = $clog2(StarveLimit + 1);
    typedef enum logic [1:0] {IDLE, WAIT, STALL, RESP} state_t;
    state_t                state_q, state_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic [DataWidth-1:0]  mem [NumRegs];
    logic [AddrWidth-1:0]  wa [NumWrPorts];
    logic [DataWidth-1:0]  wd [NumWrPorts];
    logic [AddrWidth-1:0]  ra [NumRdPorts];
    logic [DataWidth-1:0]  rd [NumRdPorts];
    logic [DataWidth-1:0]  dbg_rdata_q;
    logic                  core_wr, dbg_gnt;

    // register 0 and out-of-range addresses never hold data
    function automatic logic valid_addr(input logic [AddrWidth-1:0] a);
        return a != '0 && 32'(a) < NumRegs;
    endfunction

    for (genvar k = 0; k < NumWrPorts; k++) begin : g_wr
        assign wa[k] = bus.waddr_i[k*AddrWidth +: AddrWidth];
        assign wd[k] = bus.wdata_i[k*DataWidth +: DataWidth];
    end

    for (genvar i = 0; i < NumRdPorts; i++) begin : g_rd
        assign ra[i] = bus.raddr_i[i*AddrWidth +: AddrWidth];
        assign bus.rdata_o[i*DataWidth +: DataWidth] = rd[i];
    end

    // ascending port order lets the highest matching write port win the bypass
    always_comb begin
        for (int p = 0; p < NumRdPorts; p++) begin
            rd[p] = valid_addr(ra[p]) ? mem[ra[p]] : '0;
            for (int k = 0; k < NumWrPorts; k++)
                if (bus.we_i[k] && valid_addr(wa[k]) && wa[k] == ra[p]) rd[p] = wd[k];
        end
    end

    assign core_wr = |bus.we_i;
    assign dbg_gnt = !rst_i && bus.dbg_req_i && !core_wr && state_q != RESP;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int r = 0; r < NumRegs; r++) mem[r] <= '0;
        end else begin
            for (int k = 0; k < NumWrPorts; k++)
                if (bus.we_i[k] && valid_addr(wa[k])) mem[wa[k]] <= wd[k];
            if (dbg_gnt && bus.dbg_we_i && valid_addr(bus.dbg_addr_i)) mem[bus.dbg_addr_i] <= bus.dbg_wdata_i;
        end
    end

    // blocked requests count up to the limit; STALL holds until the core goes idle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (dbg_gnt) begin
            state_d = RESP;
            cnt_d   = '0;
        end else if (state_q == RESP || !bus.dbg_req_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (state_q != STALL) begin
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_q + 1'b1 == CntWidth'(StarveLimit)) ? STALL : WAIT;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dbg_rdata_q <= (dbg_gnt && !bus.dbg_we_i && valid_addr(bus.dbg_addr_i)) ? mem[bus.dbg_addr_i] : '0;
        end
    end

    assign bus.dbg_gnt_o    = dbg_gnt;
    assign bus.dbg_rvalid_o = state_q == RESP;
    assign bus.dbg_rdata_o  = dbg_rdata_q;
    assign bus.stall_o      = state_q == STALL;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: vector table, debug corner sequences and a randomized model check for regfile_mp
module tb_regfile_mp;
    localparam int DW = 32, NR = 32, NRD = 2, NWR = 2, SL = 4;
    logic clk_i = 1'b0;
    logic rst_i;
    int   n_cmp = 0, n_err = 0;
    always #5 clk_i = ~clk_i;

    regfile_mp_if #(.DataWidth(DW), .NumRegs(NR), .NumRdPorts(NRD), .NumWrPorts(NWR)) bus ();
    regfile_mp #(.DataWidth(DW), .NumRegs(NR), .NumRdPorts(NRD), .NumWrPorts(NWR), .StarveLimit(SL))
        dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;
    vec_t vt [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic core(input logic [1:0] we, input logic [4:0] a0, input logic [31:0] d0,
                        input logic [4:0] a1, input logic [31:0] d1, input logic [4:0] r0, input logic [4:0] r1);
        bus.we_i    = we;
        bus.waddr_i = {a1, a0};
        bus.wdata_i = {d1, d0};
        bus.raddr_i = {r1, r0};
    endtask

    task automatic dbg(input logic req, input logic we, input logic [4:0] a, input logic [31:0] d);
        bus.dbg_req_i   = req;
        bus.dbg_we_i    = we;
        bus.dbg_addr_i  = a;
        bus.dbg_wdata_i = d;
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [31:0] rdp(input int p);
        return bus.rdata_o[p*DW +: DW];
    endfunction

    logic [31:0] m [NR];
    initial begin
        vt[0] = '{2'b01, 5'd5,  32'hDEADBEEF, 5'd0,  32'h0,   5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
        vt[1] = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,   5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
        vt[2] = '{2'b11, 5'd7,  32'h11,       5'd7,  32'h22,  5'd7,  5'd5,  32'h22,       32'hDEADBEEF};
        vt[3] = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,   5'd7,  5'd0,  32'h22,       32'h0};
        vt[4] = '{2'b01, 5'd0,  32'hFFFF,     5'd0,  32'h0,   5'd0,  5'd0,  32'h0,        32'h0};
        vt[5] = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,   5'd0,  5'd7,  32'h0,        32'h22};
        vt[6] = '{2'b10, 5'd9,  32'h55,       5'd9,  32'h99,  5'd9,  5'd9,  32'h99,       32'h99};
        vt[7] = '{2'b11, 5'd10, 32'hA,        5'd11, 32'hB,   5'd10, 5'd11, 32'hA,        32'hB};
        vt[8] = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,   5'd10, 5'd11, 32'hA,        32'hB};
        vt[9] = '{2'b01, 5'd31, 32'h1F1F,     5'd0,  32'h0,   5'd31, 5'd30, 32'h1F1F,     32'h0};

        rst_i = 1'b1;
        core(2'b00, 5'd0, 0, 5'd0, 0, 5'd5, 5'd0);
        dbg(1'b0, 1'b0, 5'd0, 0);
        tick;
        tick;
        rst_i = 1'b0;
        #2;
        check("reset_gnt", 32'(bus.dbg_gnt_o), 0);
        check("reset_rvalid", 32'(bus.dbg_rvalid_o), 0);
        check("reset_stall", 32'(bus.stall_o), 0);
        check("reset_dbg_rdata", bus.dbg_rdata_o, 0);
        check("reset_rdata", rdp(0), 0);
        tick;

        for (int i = 0; i < 10; i++) begin
            core(vt[i].we, vt[i].a0, vt[i].d0, vt[i].a1, vt[i].d1, vt[i].r0, vt[i].r1);
            #2;
            check($sformatf("vec%0d_rd0", i), rdp(0), vt[i].e0);
            check($sformatf("vec%0d_rd1", i), rdp(1), vt[i].e1);
            tick;
        end
        core(2'b00, 5'd0, 0, 5'd0, 0, 5'd0, 5'd0);

        // debug read with the core idle
        dbg(1'b1, 1'b0, 5'd5, 0);
        #2;
        check("dbgrd_gnt", 32'(bus.dbg_gnt_o), 1);
        tick;
        dbg(1'b0, 1'b0, 5'd0, 0);
        check("dbgrd_rvalid", 32'(bus.dbg_rvalid_o), 1);
        check("dbgrd_rdata", bus.dbg_rdata_o, 32'hDEADBEEF);
        check("dbgrd_resp_gnt", 32'(bus.dbg_gnt_o), 0);
        tick;
        check("dbgrd_rvalid_drop", 32'(bus.dbg_rvalid_o), 0);

        // starvation: core writes every cycle until the stall is raised
        dbg(1'b1, 1'b1, 5'd3, 32'h1234);
        for (int c = 0; c < 4; c++) begin
            core(2'b01, 5'd20, 32'(c + 1), 5'd0, 0, 5'd20, 5'd3);
            #2;
            check($sformatf("starve%0d_gnt", c), 32'(bus.dbg_gnt_o), 0);
            check($sformatf("starve%0d_stall", c), 32'(bus.stall_o), 0);
            tick;
        end
        core(2'b01, 5'd20, 32'h5, 5'd0, 0, 5'd20, 5'd3);
        #2;
        check("stall_rise", 32'(bus.stall_o), 1);
        check("stall_core_wins_gnt", 32'(bus.dbg_gnt_o), 0);
        tick;
        core(2'b00, 5'd0, 0, 5'd0, 0, 5'd20, 5'd3);
        #2;
        check("stall_hold", 32'(bus.stall_o), 1);
        check("stall_gnt", 32'(bus.dbg_gnt_o), 1);
        check("stall_core_write_kept", rdp(0), 32'h5);
        check("dbg_no_bypass", rdp(1), 0);
        tick;
        dbg(1'b0, 1'b0, 5'd0, 0);
        check("dbgwr_rvalid", 32'(bus.dbg_rvalid_o), 1);
        check("dbgwr_rdata_zero", bus.dbg_rdata_o, 0);
        check("dbgwr_stall_drop", 32'(bus.stall_o), 0);
        check("dbgwr_x3", rdp(1), 32'h1234);
        tick;

        // core and debug write the same register in the same cycle
        core(2'b01, 5'd12, 32'hAAAA, 5'd0, 0, 5'd12, 5'd12);
        dbg(1'b1, 1'b1, 5'd12, 32'hBBBB);
        #2;
        check("samereg_gnt0", 32'(bus.dbg_gnt_o), 0);
        check("samereg_bypass", rdp(0), 32'hAAAA);
        tick;
        core(2'b00, 5'd0, 0, 5'd0, 0, 5'd12, 5'd12);
        #2;
        check("samereg_gnt1", 32'(bus.dbg_gnt_o), 1);
        check("samereg_core_first", rdp(0), 32'hAAAA);
        tick;
        dbg(1'b0, 1'b0, 5'd0, 0);
        check("samereg_dbg_val", rdp(0), 32'hBBBB);
        tick;
        tick;
        check("samereg_persist", rdp(1), 32'hBBBB);

        // debug accesses to register 0
        dbg(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF);
        #2;
        check("x0_wr_gnt", 32'(bus.dbg_gnt_o), 1);
        tick;
        dbg(1'b0, 1'b0, 5'd0, 0);
        tick;
        dbg(1'b1, 1'b0, 5'd0, 0);
        core(2'b00, 5'd0, 0, 5'd0, 0, 5'd0, 5'd0);
        #2;
        check("x0_rd_gnt", 32'(bus.dbg_gnt_o), 1);
        tick;
        dbg(1'b0, 1'b0, 5'd0, 0);
        check("x0_rd_rvalid", 32'(bus.dbg_rvalid_o), 1);
        check("x0_rd_rdata", bus.dbg_rdata_o, 0);
        check("x0_core_rd", rdp(0), 0);
        tick;

        // dropping the request in WAIT clears the starvation count
        core(2'b01, 5'd21, 32'h7, 5'd0, 0, 5'd0, 5'd0);
        dbg(1'b1, 1'b0, 5'd5, 0);
        tick;
        bus.dbg_req_i = 1'b0;
        tick;
        bus.dbg_req_i = 1'b1;
        tick;
        tick;
        tick;
        check("abort_cnt_cleared", 32'(bus.stall_o), 0);
        tick;
        check("abort_stall_after4", 32'(bus.stall_o), 1);

        // asynchronous reset while in STALL
        #3;
        core(2'b00, 5'd0, 0, 5'd0, 0, 5'd5, 5'd21);
        rst_i = 1'b1;
        #1;
        check("arst_stall", 32'(bus.stall_o), 0);
        check("arst_gnt", 32'(bus.dbg_gnt_o), 0);
        check("arst_rvalid", 32'(bus.dbg_rvalid_o), 0);
        check("arst_x5", rdp(0), 0);
        check("arst_x21", rdp(1), 0);
        #2;
        rst_i = 1'b0;
        #1;
        check("arst_idle_nostall", 32'(bus.stall_o), 0);
        check("arst_idle_gnt", 32'(bus.dbg_gnt_o), 1);
        bus.dbg_req_i = 1'b0;
        tick;
        check("arst_no_write", rdp(0), 0);

        // randomized run against a behavioural model
        begin
            logic [1:0]  we;
            logic [4:0]  wa [2];
            logic [31:0] wd [2];
            logic [4:0]  ra [2];
            logic [31:0] exp, lrd, nl;
            logic        preq, gl, eg, dw;
            logic [4:0]  da;
            logic [31:0] dd;
            int          blk;
            for (int r = 0; r < NR; r++) m[r] = 0;
            preq = 0; gl = 0; lrd = 0; blk = 0; dw = 0; da = 0; dd = 0;
            for (int cyc = 0; cyc < 2000; cyc++) begin
                if (!preq && $urandom_range(0, 3) == 0) begin
                    preq = 1;
                    dw = 1'($urandom);
                    da = 5'($urandom_range(0, 7));
                    dd = $urandom;
                end
                dbg(preq, dw, da, dd);
                if ((cyc / 40) % 2 == 1) we = 2'($urandom_range(1, 3));
                else we = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                for (int k = 0; k < 2; k++) begin
                    wa[k] = 5'($urandom_range(0, 7));
                    wd[k] = $urandom;
                    ra[k] = 5'($urandom_range(0, 7));
                end
                core(we, wa[0], wd[0], wa[1], wd[1], ra[0], ra[1]);
                #2;
                for (int p = 0; p < 2; p++) begin
                    exp = (ra[p] == 0) ? 0 : m[ra[p]];
                    for (int k = 0; k < 2; k++)
                        if (we[k] && wa[k] != 0 && wa[k] == ra[p]) exp = wd[k];
                    check($sformatf("rnd%0d_rd%0d", cyc, p), rdp(p), exp);
                end
                eg = preq && we == 0 && !gl;
                check($sformatf("rnd%0d_gnt", cyc), 32'(bus.dbg_gnt_o), 32'(eg));
                check($sformatf("rnd%0d_stall", cyc), 32'(bus.stall_o), 32'(blk >= SL));
                check($sformatf("rnd%0d_rvalid", cyc), 32'(bus.dbg_rvalid_o), 32'(gl));
                check($sformatf("rnd%0d_dbg_rdata", cyc), bus.dbg_rdata_o, gl ? lrd : 0);
                nl = (eg && !dw && da != 0) ? m[da] : 0;
                for (int k = 0; k < 2; k++)
                    if (we[k] && wa[k] != 0) m[wa[k]] = wd[k];
                if (eg && dw && da != 0) m[da] = dd;
                blk = (eg || gl || !preq) ? 0 : blk + 1;
                gl = eg;
                lrd = nl;
                if (eg) preq = 0;
                tick;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port general-purpose register file for the tinyriscv core. It is the successor of the fixed 2-read/1-write file, with N read ports, M write ports and write-to-read bypass. It adds a req/gnt debug access port with an anti-starvation stall. It sits between the ID stage (reads), the EX/WB stages (writes) and the JTAG debug module.

Parameters:
DataWidth, 32, register width in bits
NumRegs, 32, number of architectural registers; register 0 is hardwired to zero
NumRdPorts, 2, number of core read ports
NumWrPorts, 1, number of core write ports
StarveLimit, 4, consecutive blocked debug-request cycles before a stall is forced (≥1)
AddrWidth, $clog2(NumRegs), derived; not overridable

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
we_i  in  NumWrPorts  per-port write enable
waddr_i  in  NumWrPorts*AddrWidth  write addresses; port k occupies bits [k*AddrWidth +: AddrWidth]
wdata_i  in  NumWrPorts*DataWidth  write data, packed the same way
raddr_i  in  NumRdPorts*AddrWidth  read addresses
rdata_o  out  NumRdPorts*DataWidth  read data (combinational)
dbg_req_i  in  1  debug access request; held high until granted
dbg_we_i  in  1  debug write (1) or read (0); stable while dbg_req_i is high
dbg_addr_i  in  AddrWidth  debug register address
dbg_wdata_i  in  DataWidth  debug write data
dbg_gnt_o  out  1  one-cycle grant; the access takes effect at this clock edge
dbg_rvalid_o  out  1  registered; high the cycle after dbg_gnt_o for reads and writes
dbg_rdata_o  out  DataWidth  registered read data, valid with dbg_rvalid_o; 0 for writes
stall_o  out  1  registered request for the core to suppress all writes this cycle

Behaviour:
- Clock/reset: single clock clk_i. rst_i is asynchronous and active-high.
- Reset state: all registers 0, FSM IDLE, starvation counter 0. dbg_gnt_o, dbg_rvalid_o and stall_o are 0; dbg_rdata_o is 0.
- A reset asserted mid-access aborts it: no grant, no write.
- Register 0 reads always return 0. Writes to register 0 from any source are discarded.
- Addresses ≥ NumRegs: writes are discarded and reads return 0.
- Core write: committed at the clock edge when the enable bit is set.
- Same-address writes in one cycle: the highest port index wins.
- Read bypass:
  - Each read port returns wdata of the highest-index active write port whose address matches (address ≠ 0).
  - Otherwise it returns the stored value.
  - Zero-latency, purely combinational.
- Debug accesses are never bypassed to core read ports.
- Debug FSM:
  - IDLE:
    - If dbg_req_i is high and all we_i are 0: assert dbg_gnt_o combinationally and perform the access at this edge. A write updates the register; a read captures the stored value into dbg_rdata_o. Next state RESP.
    - If dbg_req_i is high but a core write is active: counter +1, state WAIT.
  - WAIT:
    - Grant under the same idle condition as IDLE, then go to RESP.
    - Otherwise counter +1. When the counter reaches StarveLimit, go to STALL.
  - STALL:
    - stall_o = 1.
    - Grant if all we_i are 0, then go to RESP.
    - If the core still writes, the core write wins and the FSM remains in STALL (no data loss).
  - RESP: dbg_rvalid_o = 1 for one cycle, counter cleared, then IDLE.
  - The next request can be granted at the earliest 2 cycles after the previous grant.
- dbg_req_i dropping in WAIT or STALL (protocol violation): return to IDLE, counter cleared.
- Debug register-0 accesses: writes are granted but ignored; reads return 0.

Test Plan:
- Reset, then write x5=0xDEADBEEF via port 0 and read raddr=5 on both ports in the same cycle → both return 0xDEADBEEF (bypass); next cycle the stored value is 0xDEADBEEF.
- NumWrPorts=2, both ports write x7 (0x11 on port 0, 0x22 on port 1) → same-cycle read and later read both return 0x22. Write to x0 → reads 0.
- Debug read x5 while we_i is idle → dbg_gnt_o in the request cycle; next cycle dbg_rvalid_o=1 and dbg_rdata_o=0xDEADBEEF.
- Debug write x3=0x1234 while the core writes every cycle, StarveLimit=4 → stall_o rises after 4 blocked cycles. Bench drops we_i → grant that cycle, then x3 reads 0x1234 on a core port.
- Core write in the same cycle as a debug request to the same register → core write commits first; debug write is granted on the next idle cycle and its value persists.
- Assert rst_i asynchronously while in STALL → stall_o, dbg_gnt_o and dbg_rvalid_o drop immediately, all registers read 0, FSM returns to IDLE.
